// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: pipelined instruction fetch with in-order response tracking, a DEPTH-entry
// decode queue and redirect flush that drops stale responses.
// Optional feature macro IFQ_BYPASS_EN: a response landing on an empty head is forwarded to
// decode in the same cycle instead of waiting one cycle in the queue.
module inst_fetch_queue #(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] inst_mem_addr,
    output logic              inst_addr_valid,
    input  logic              inst_mem_ready,
    input  logic              inst_mem_valid,
    input  logic [INST_W-1:0] inst_mem_data,
    output logic              id_valid,
    input  logic              id_ready,
    output logic [ADDR_W-1:0] id_pc,
    output logic [INST_W-1:0] id_inst
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] pc_q [DEPTH];
    logic [INST_W-1:0] inst_q [DEPTH];
    logic [DEPTH-1:0] filled;
    logic [PW-1:0] alloc_ptr, fill_ptr, rd_ptr;
    logic [CW-1:0] used, inflight, drop_cnt;
    logic accept, resp, resp_keep, pop, bypass;

    assign inst_mem_addr = fetch_pc;
    assign id_pc = pc_q[rd_ptr];

    // Handshake decode: issue gating, response classification and head presentation.
    always_comb begin
        resp = inst_mem_valid && (inflight != '0);
        resp_keep = resp && (drop_cnt == '0);
`ifdef IFQ_BYPASS_EN
        bypass = resp_keep && !filled[rd_ptr] && (fill_ptr == rd_ptr);
`else
        bypass = 1'b0;
`endif
        inst_addr_valid = !rst && !redirect_valid && (used < FULL) && (inflight < FULL);
        accept = inst_addr_valid && inst_mem_ready;
        id_valid = filled[rd_ptr] || bypass;
        id_inst = bypass ? inst_mem_data : inst_q[rd_ptr];
        pop = id_valid && id_ready && !redirect_valid;
    end

    // Queue, pointer and counter state; redirect flushes everything and marks in-flight data stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            alloc_ptr <= '0;
            fill_ptr <= '0;
            rd_ptr <= '0;
            used <= '0;
            inflight <= '0;
            drop_cnt <= '0;
            filled <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i] <= '0;
                inst_q[i] <= '0;
            end
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~ADDR_W'(3);
            alloc_ptr <= '0;
            fill_ptr <= '0;
            rd_ptr <= '0;
            used <= '0;
            filled <= '0;
            inflight <= inflight - CW'(resp);
            drop_cnt <= inflight - CW'(resp);
        end else begin
            if (accept) begin
                pc_q[alloc_ptr] <= fetch_pc;
                alloc_ptr <= alloc_ptr + PW'(1);
                fetch_pc <= fetch_pc + ADDR_W'(4);
            end
            if (resp_keep) begin
                inst_q[fill_ptr] <= inst_mem_data;
                fill_ptr <= fill_ptr + PW'(1);
                if (!(bypass && pop))
                    filled[fill_ptr] <= 1'b1;
            end
            if (pop) begin
                filled[rd_ptr] <= 1'b0;
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (resp && (drop_cnt != '0))
                drop_cnt <= drop_cnt - CW'(1);
            used <= used + CW'(accept) - CW'(pop);
            inflight <= inflight + CW'(accept) - CW'(resp);
        end
    end

    // A response with nothing outstanding is a memory protocol violation.
    assert property (@(posedge clk) disable iff (rst) inst_mem_valid |-> (inflight != '0));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: scoreboard bench for inst_fetch_queue with a 1-cycle pipelined memory model.
module tb_inst_fetch_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic [63:0] inst_mem_addr;
    logic        inst_addr_valid;
    logic        inst_mem_ready = 1'b0;
    logic        inst_mem_valid;
    logic [31:0] inst_mem_data;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [63:0] id_pc;
    logic [31:0] id_inst;

    logic        resp_en = 1'b1;
    logic [63:0] model_pc;
    logic [63:0] exp_q[$];
    logic [63:0] pend[$];
    logic [63:0] sb_e;
    int checks = 0;
    int errors = 0;
    int accepts = 0;
    int pops = 0;

`ifdef IFQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    inst_fetch_queue dut (
        .clk(clk),
        .rst(rst),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .inst_mem_addr(inst_mem_addr),
        .inst_addr_valid(inst_addr_valid),
        .inst_mem_ready(inst_mem_ready),
        .inst_mem_valid(inst_mem_valid),
        .inst_mem_data(inst_mem_data),
        .id_valid(id_valid),
        .id_ready(id_ready),
        .id_pc(id_pc),
        .id_inst(id_inst)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] data_of(input logic [63:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    // Scoreboard: check pops against expected order, track redirects, check and record requests.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_pc = 64'h0;
            accepts = 0;
        end else begin
            if (id_valid && id_ready && !redirect_valid) begin
                pops++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_order: popped pc=%h inst=%h, none expected", id_pc, id_inst);
                end else begin
                    sb_e = exp_q.pop_front();
                    if (id_pc !== sb_e || id_inst !== data_of(sb_e)) begin
                        errors++;
                        $display("FAIL pop_order: got pc=%h inst=%h, want pc=%h inst=%h",
                                 id_pc, id_inst, sb_e, data_of(sb_e));
                    end
                end
            end
            if (redirect_valid) begin
                exp_q.delete();
                model_pc = redirect_pc & ~64'h3;
            end
            if (inst_addr_valid && inst_mem_ready) begin
                checks++;
                if (inst_mem_addr !== model_pc) begin
                    errors++;
                    $display("FAIL req_addr: got %h, want %h", inst_mem_addr, model_pc);
                end
                exp_q.push_back(model_pc);
                pend.push_back(inst_mem_addr);
                model_pc = model_pc + 64'h4;
                accepts++;
            end
        end
    end

    // Memory model: one in-order response per accepted request, one cycle later when enabled.
    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            inst_mem_valid <= 1'b0;
            inst_mem_data <= '0;
        end else begin
            if (inst_mem_valid && pend.size() != 0)
                void'(pend.pop_front());
            inst_mem_valid <= resp_en && (pend.size() != 0);
            if (pend.size() != 0)
                inst_mem_data <= data_of(pend[0]);
            else
                inst_mem_data <= '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        inst_mem_ready = 1'b0;
        id_ready = 1'b0;
        resp_en = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        checks++;
        if (inst_addr_valid !== 1'b0 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valids: addr_valid=%b id_valid=%b, want 0 0", inst_addr_valid, id_valid);
        end
        checks++;
        if (inst_mem_addr !== 64'h0 || id_pc !== 64'h0 || id_inst !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h id_pc=%h id_inst=%h, want 0", inst_mem_addr, id_pc, id_inst);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (inst_addr_valid !== 1'b1 || inst_mem_addr !== 64'h0) begin
            errors++;
            $display("FAIL reset_first_req: valid=%b addr=%h, want 1 0", inst_addr_valid, inst_mem_addr);
        end
    endtask

    task automatic test_stream();
        int n = 0;
        do_reset();
        inst_mem_ready = 1'b1;
        id_ready = 1'b1;
        repeat (4) tick();
        repeat (16) begin
            @(negedge clk);
            if (id_valid === 1'b1) n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL stream_no_bubble: id_valid cycles=%0d, want 16", n);
        end
    endtask

    task automatic test_stall();
        int p0;
        bit ok = 0;
        do_reset();
        inst_mem_ready = 1'b1;
        id_ready = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        checks++;
        if (accepts != 4) begin
            errors++;
            $display("FAIL stall_accepts: got %0d, want 4", accepts);
        end
        checks++;
        if (inst_addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_issue: addr_valid=%b, want 0", inst_addr_valid);
        end
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 64'h0) begin
            errors++;
            $display("FAIL stall_head: id_valid=%b id_pc=%h, want 1 0", id_valid, id_pc);
        end
        tick();
        p0 = pops;
        id_ready = 1'b1;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (inst_addr_valid === 1'b1) ok = 1;
        end
        checks++;
        if (!ok || inst_mem_addr !== 64'h10) begin
            errors++;
            $display("FAIL stall_resume: seen=%0d addr=%h, want 1 0000000000000010", ok, inst_mem_addr);
        end
        repeat (6) tick();
        checks++;
        if (pops - p0 < 4) begin
            errors++;
            $display("FAIL stall_drain: pops=%0d, want >=4", pops - p0);
        end
    endtask

    task automatic test_mem_stall();
        do_reset();
        inst_mem_ready = 1'b1;
        id_ready = 1'b1;
        repeat (2) tick();
        inst_mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (inst_addr_valid !== 1'b1 || inst_mem_addr !== 64'h8) begin
                errors++;
                $display("FAIL mem_stall_hold[%0d]: valid=%b addr=%h, want 1 0000000000000008",
                         i, inst_addr_valid, inst_mem_addr);
            end
        end
        tick();
        inst_mem_ready = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_redirect();
        bit ok = 0;
        do_reset();
        resp_en = 1'b0;
        inst_mem_ready = 1'b1;
        id_ready = 1'b1;
        repeat (3) tick();
        inst_mem_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h1002;
        @(negedge clk);
        checks++;
        if (inst_addr_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_no_issue: addr_valid=%b, want 0", inst_addr_valid);
        end
        tick();
        redirect_valid = 1'b0;
        inst_mem_ready = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);
        checks++;
        if (inst_addr_valid !== 1'b1 || inst_mem_addr !== 64'h1000) begin
            errors++;
            $display("FAIL redirect_target: valid=%b addr=%h, want 1 0000000000001000", inst_addr_valid, inst_mem_addr);
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (id_valid === 1'b1) ok = 1;
        end
        checks++;
        if (!ok || id_pc !== 64'h1000 || id_inst !== data_of(64'h1000)) begin
            errors++;
            $display("FAIL redirect_first: seen=%0d pc=%h inst=%h, want pc=0000000000001000 inst=%h",
                     ok, id_pc, id_inst, data_of(64'h1000));
        end
        repeat (4) tick();
    endtask

    task automatic test_redirect_pop();
        bit ok = 0;
        do_reset();
        inst_mem_ready = 1'b1;
        id_ready = 1'b1;
        repeat (6) tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h2000;
        @(negedge clk);
        checks++;
        if (inst_mem_valid !== 1'b1 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_pop_setup: mem_valid=%b id_valid=%b, want 1 1", inst_mem_valid, id_valid);
        end
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_pop_empty: id_valid=%b, want 0", id_valid);
        end
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (id_valid === 1'b1) ok = 1;
        end
        checks++;
        if (!ok || id_pc !== 64'h2000 || id_inst !== data_of(64'h2000)) begin
            errors++;
            $display("FAIL redirect_pop_first: seen=%0d pc=%h inst=%h, want pc=0000000000002000 inst=%h",
                     ok, id_pc, id_inst, data_of(64'h2000));
        end
        repeat (4) tick();
    endtask

    task automatic test_back_to_back();
        bit ok = 0;
        do_reset();
        resp_en = 1'b0;
        inst_mem_ready = 1'b1;
        id_ready = 1'b1;
        repeat (2) tick();
        inst_mem_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h3000;
        tick();
        redirect_pc = 64'h4000;
        tick();
        redirect_valid = 1'b0;
        inst_mem_ready = 1'b1;
        resp_en = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (id_valid === 1'b1) ok = 1;
        end
        checks++;
        if (!ok || id_pc !== 64'h4000 || id_inst !== data_of(64'h4000)) begin
            errors++;
            $display("FAIL back_to_back: seen=%0d pc=%h inst=%h, want pc=0000000000004000 inst=%h",
                     ok, id_pc, id_inst, data_of(64'h4000));
        end
        repeat (4) tick();
    endtask

    task automatic test_latency();
        bit ok = 0;
        do_reset();
        inst_mem_ready = 1'b1;
        id_ready = 1'b0;
        tick();
        inst_mem_ready = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            if (inst_mem_valid === 1'b1) ok = 1;
        end
        checks++;
        if (!ok || id_valid !== BYP) begin
            errors++;
            $display("FAIL latency_same_cycle: seen=%0d id_valid=%b, want %b", ok, id_valid, BYP);
        end
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 64'h0 || id_inst !== data_of(64'h0)) begin
            errors++;
            $display("FAIL latency_next_cycle: id_valid=%b pc=%h inst=%h, want 1 0 %h",
                     id_valid, id_pc, id_inst, data_of(64'h0));
        end
        tick();
        id_ready = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_mem_stall();
        test_redirect();
        test_redirect_pop();
        test_back_to_back();
        test_latency();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
